// File: rtl/nios_project_pio_in_edge_if.sv
// Avalon-MM slave bundle for the edge-capturing PIO input port.
interface nios_project_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_project_pio_in_edge.sv
// Avalon-MM input PIO: 2-flop sync, per-bit debounce, edge capture, masked level IRQ.
// Build option: define PIO_DEBOUNCE_EN to instantiate the debounce counters.
module nios_project_pio_in_edge #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  nios_project_pio_in_edge_if.slave  bus,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= in_port;
      sync_q <= meta_q;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] deb_cnt [WIDTH];

  // Accept a new level only after it differs from deb_q for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb_q[i]   <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1'b1);
        end
      end
    end
  end
`else
  // Without debouncing the cycle count has no role.
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
    end else begin
      deb_q <= sync_q;
    end
  end
`endif

  // Per-bit edge events from the debounced level and its one-cycle-old copy.
  always_comb begin
    edge_evt = '0;
    case (EDGE_TYPE)
      32'sd0:  edge_evt = deb_q & ~prev_q;
      32'sd1:  edge_evt = ~deb_q & prev_q;
      default: edge_evt = deb_q ^ prev_q;
    endcase
  end

  always_comb begin
    cap_clr = '0;
    if (wr_en && (bus.address == ADDR_CAP)) begin
      cap_clr = bus.writedata[WIDTH-1:0];
    end else begin
      cap_clr = '0;
    end
  end

  always_comb begin
    rd_mux = 32'h0000_0000;
    case (bus.address)
      ADDR_DATA: rd_mux = 32'(deb_q);
      ADDR_RSVD: rd_mux = 32'h0000_0000;
      ADDR_MASK: rd_mux = 32'(irq_mask);
      ADDR_CAP:  rd_mux = 32'(edge_cap);
      default:   rd_mux = 32'h0000_0000;
    endcase
  end

  // Capture and mask registers; a new event beats a same-cycle W1C on that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      edge_cap     <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
      bus.readdata <= 32'h0000_0000;
    end else begin
      prev_q       <= deb_q;
      edge_cap     <= (edge_cap & ~cap_clr) | edge_evt;
      irq          <= |(edge_cap & irq_mask);
      bus.readdata <= rd_mux;
      if (wr_en && (bus.address == ADDR_MASK)) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end else begin
        irq_mask <= irq_mask;
      end
    end
  end

endmodule

// File: tb/tb_nios_project_pio_in_edge.sv
// Randomised self-checking bench: two DUTs (rising and any-edge) against a history-based reference model.
module tb_nios_project_pio_in_edge;

  localparam int W = 10;
  localparam int D = 4;
`ifdef PIO_DEBOUNCE_EN
  localparam int D_EFF = D;
`else
  localparam int D_EFF = 1;
`endif
  localparam int   LAT         = 2 + D_EFF;
  localparam int   G           = (D_EFF > 1) ? D_EFF - 1 : 1;
  localparam logic GLITCH_SEEN = (G >= D_EFF);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq0;
  logic         irq2;

  nios_project_pio_in_edge_if bus0 ();
  nios_project_pio_in_edge_if bus2 ();

  nios_project_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port), .irq(irq0));
  nios_project_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port), .irq(irq2));

  always #5 clk = ~clk;

  // Reference model: samp[k] is the in_port value seen at the k-th most recent edge.
  logic [W-1:0] samp [8];
  logic [W-1:0] m_deb, m_prev, m_cap0, m_cap2, m_mask;
  logic         m_irq0, m_irq2;
  logic [31:0]  m_rd0, m_rd2;
  int checks = 0;
  int errors = 0;

  task automatic model_reset;
    for (int j = 0; j < 8; j++) samp[j] = '0;
    m_deb = '0; m_prev = '0; m_cap0 = '0; m_cap2 = '0; m_mask = '0;
    m_irq0 = 1'b0; m_irq2 = 1'b0; m_rd0 = 32'h0; m_rd2 = 32'h0;
  endtask

  function automatic logic [31:0] reg_view(input logic [1:0] a, input logic [W-1:0] cap);
    case (a)
      2'd0:    return 32'(m_deb);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(cap);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge;
    logic [W-1:0] nd, ev0, ev2, clr;
    logic wr, all_same;
    nd = m_deb;
    // a bit flips once the synchronised input has shown the opposite level D_EFF edges running
    for (int i = 0; i < W; i++) begin
      all_same = 1'b1;
      for (int j = 1; j <= D_EFF; j++) if (samp[j][i] === m_deb[i]) all_same = 1'b0;
      if (all_same) nd[i] = ~m_deb[i];
    end
    ev0 = m_deb & ~m_prev;
    ev2 = m_deb ^ m_prev;
    wr  = bus0.chipselect && !bus0.write_n;
    clr = (wr && bus0.address == 2'd3) ? bus0.writedata[W-1:0] : '0;
    m_rd0  = reg_view(bus0.address, m_cap0);
    m_rd2  = reg_view(bus0.address, m_cap2);
    m_irq0 = |(m_cap0 & m_mask);
    m_irq2 = |(m_cap2 & m_mask);
    m_cap0 = (m_cap0 & ~clr) | ev0;
    m_cap2 = (m_cap2 & ~clr) | ev2;
    if (wr && bus0.address == 2'd2) m_mask = bus0.writedata[W-1:0];
    m_prev = m_deb;
    m_deb  = nd;
    for (int j = 7; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = in_port;
  endtask

  task automatic drive_bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
    bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_port = 10'h3FF;
    drive_bus(2'd0, 1'b0, 1'b1, 32'h0);
    model_reset();
    repeat (3) tick();
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL reset_rd0 got=%h exp=0", bus0.readdata); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq0 got=%b exp=0", irq0); end
    checks++; if (bus2.readdata !== 32'h0) begin errors++; $display("FAIL reset_rd2 got=%h exp=0", bus2.readdata); end
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL reset_irq2 got=%b exp=0", irq2); end
    reset_n = 1'b1;
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    repeat (LAT + 2) tick();
    checks++; if (bus0.readdata !== 32'h3FF) begin errors++; $display("FAIL powerup_edge got=%h exp=3ff", bus0.readdata); end
    drive_bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick();
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL init_clear got=%h exp=0", bus0.readdata); end
    in_port = '0;
    repeat (LAT + 2) tick();
    drive_bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
  endtask

  task automatic test_debounce;
    logic seen;
    seen = 1'b0;
    drive_bus(2'd0, 1'b0, 1'b1, 32'h0);
    in_port[0] = 1'b1;
    repeat (G) begin tick(); seen |= bus0.readdata[0]; end
    in_port[0] = 1'b0;
    repeat (LAT + 3) begin tick(); seen |= bus0.readdata[0]; end
    checks++; if (seen !== GLITCH_SEEN) begin errors++; $display("FAIL glitch got=%b exp=%b", seen, GLITCH_SEEN); end
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL glitch_end got=%h exp=0", bus0.readdata); end
    in_port[0] = 1'b1;
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      checks++;
      if (bus0.readdata !== ((t >= LAT + 1) ? 32'h1 : 32'h0))
        begin errors++; $display("FAIL step_lat t=%0d got=%h", t, bus0.readdata); end
    end
    in_port = 10'h155;
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      checks++;
      if (bus0.readdata !== ((t >= LAT + 1) ? 32'h155 : 32'h1))
        begin errors++; $display("FAIL step155 t=%0d got=%h", t, bus0.readdata); end
    end
    checks++; if (bus2.readdata !== 32'h155) begin errors++; $display("FAIL step155_dut2 got=%h exp=155", bus2.readdata); end
  endtask

  task automatic test_edge_irq;
    in_port = '0;
    drive_bus(2'd0, 1'b0, 1'b1, 32'h0);
    repeat (LAT + 2) tick();
    drive_bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive_bus(2'd2, 1'b1, 1'b0, 32'h0000_0001);
    tick();
    drive_bus(2'd2, 1'b0, 1'b1, 32'h0);
    tick();
    checks++; if (bus0.readdata !== 32'h1) begin errors++; $display("FAIL mask_rd got=%h exp=1", bus0.readdata); end
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port[0] = 1'b1;
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      checks++;
      if (irq0 !== (t >= LAT + 2)) begin errors++; $display("FAIL irq_rise t=%0d got=%b", t, irq0); end
      checks++;
      if (bus0.readdata !== ((t >= LAT + 2) ? 32'h1 : 32'h0))
        begin errors++; $display("FAIL cap_rise t=%0d got=%h", t, bus0.readdata); end
    end
    drive_bus(2'd3, 1'b1, 1'b0, 32'h0000_0001);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", irq0); end
    tick();
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=0", irq0); end
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL cap_clear got=%h exp=0", bus0.readdata); end
  endtask

  task automatic test_collision;
    logic found;
    found = 1'b0;
    drive_bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port[3] = 1'b1;
    for (int k = 0; k < LAT + 6 && !found; k++) begin
      if (m_deb[3] && !m_prev[3]) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL collide_timeout got=0 exp=1"); end
    drive_bus(2'd3, 1'b1, 1'b0, 32'h0000_0008);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick();
    checks++; if (bus0.readdata[3] !== 1'b1) begin errors++; $display("FAIL collide0 got=%h exp bit3=1", bus0.readdata); end
    checks++; if (bus2.readdata[3] !== 1'b1) begin errors++; $display("FAIL collide2 got=%h exp bit3=1", bus2.readdata); end
    drive_bus(2'd3, 1'b1, 1'b0, 32'h0000_0008);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick();
    checks++; if (bus0.readdata[3] !== 1'b0) begin errors++; $display("FAIL w1c_plain got=%h exp bit3=0", bus0.readdata); end
  endtask

  task automatic test_edge_any;
    drive_bus(2'd2, 1'b1, 1'b0, 32'h0000_0200);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port[9] = 1'b1;
    repeat (LAT + 3) tick();
    drive_bus(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive_bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port[9] = 1'b0;
    repeat (LAT + 3) tick();
    checks++; if (bus2.readdata !== 32'h200) begin errors++; $display("FAIL any_cap got=%h exp=200", bus2.readdata); end
    checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_irq got=%b exp=1", irq2); end
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL rise_nofall got=%h exp=0", bus0.readdata); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rise_noirq got=%b exp=0", irq0); end
    drive_bus(2'd0, 1'b1, 1'b0, 32'h0000_FFFF);
    tick();
    drive_bus(2'd0, 1'b0, 1'b1, 32'h0);
    tick();
    checks++; if (bus0.readdata !== 32'(in_port)) begin errors++; $display("FAIL data_ro got=%h exp=%h", bus0.readdata, 32'(in_port)); end
    drive_bus(2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive_bus(2'd1, 1'b0, 1'b1, 32'h0);
    tick();
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL reserved got=%h exp=0", bus0.readdata); end
  endtask

  task automatic test_async_reset;
    in_port = 10'h3C0;
    drive_bus(2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive_bus(2'd0, 1'b0, 1'b1, 32'h0);
    repeat (LAT + 3) tick();
    checks++; if (bus0.readdata !== 32'h3C0) begin errors++; $display("FAIL pre_reset_rd got=%h exp=3c0", bus0.readdata); end
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq0); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL async_rd0 got=%h exp=0", bus0.readdata); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL async_irq0 got=%b exp=0", irq0); end
    checks++; if (bus2.readdata !== 32'h0) begin errors++; $display("FAIL async_rd2 got=%h exp=0", bus2.readdata); end
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL async_irq2 got=%b exp=0", irq2); end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_random;
    int op;
    logic [1:0] a;
    logic [31:0] wd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, W - 1);
        in_port[op] = ~in_port[op];
      end
      op = $urandom_range(0, 9);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      case (op)
        0, 1:    drive_bus(2'd3, 1'b1, 1'b0, wd);
        2:       drive_bus(2'd2, 1'b1, 1'b0, wd);
        3:       drive_bus(a, 1'b1, 1'b0, wd);
        4:       drive_bus(a, 1'b0, 1'b0, wd);
        default: drive_bus(a, 1'($urandom_range(0, 1)), 1'b1, wd);
      endcase
      tick();
      checks++; if (bus0.readdata !== m_rd0) begin errors++; $display("FAIL rand_rd0 cyc=%0d got=%h exp=%h", cyc, bus0.readdata, m_rd0); end
      checks++; if (bus2.readdata !== m_rd2) begin errors++; $display("FAIL rand_rd2 cyc=%0d got=%h exp=%h", cyc, bus2.readdata, m_rd2); end
      checks++; if (irq0 !== m_irq0) begin errors++; $display("FAIL rand_irq0 cyc=%0d got=%b exp=%b", cyc, irq0, m_irq0); end
      checks++; if (irq2 !== m_irq2) begin errors++; $display("FAIL rand_irq2 cyc=%0d got=%b exp=%b", cyc, irq2, m_irq2); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_edge_irq();
    test_collision();
    test_edge_any();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
